// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port among NREQ requesters.
// Optional SPRITE_ARB_BIRD_PRIO_EN gives requester 0 absolute priority.
module sprite_rom_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = 14,
    parameter int unsigned DW      = 12,
    parameter int unsigned ROM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 frame_start,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    output logic [NREQ-1:0]      gnt,
    output logic                 rom_en,
    output logic [AW-1:0]        rom_addr,
    input  logic [DW-1:0]        rom_data,
    output logic [NREQ-1:0]      rd_valid,
    output logic [DW-1:0]        rd_data,
    output logic                 busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]                 ptr_q, ptr_d;
    logic                          rom_en_q, rom_en_d;
    logic [AW-1:0]                 rom_addr_q, rom_addr_d;
    logic [ROM_LAT:0][NREQ-1:0]    tag_q, tag_d;
    logic [NREQ-1:0]               rd_valid_q, rd_valid_d;
    logic [DW-1:0]                 rd_data_q, rd_data_d;

    logic [NREQ-1:0]               gnt_oh;
    logic [PW-1:0]                 gnt_idx;
    logic                          gnt_any;
    logic [PW-1:0]                 cand;

    // First asserted request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PW'((32'(ptr_q) + k) % NREQ);
`ifdef SPRITE_ARB_BIRD_PRIO_EN
            if (!gnt_any && req[cand] && (cand != '0)) begin
`else
            if (!gnt_any && req[cand]) begin
`endif
                gnt_any      = 1'b1;
                gnt_idx      = cand;
                gnt_oh       = '0;
                gnt_oh[cand] = 1'b1;
            end
        end
`ifdef SPRITE_ARB_BIRD_PRIO_EN
        if (req[0]) begin
            gnt_any = 1'b1;
            gnt_idx = '0;
            gnt_oh  = '0;
            gnt_oh[0] = 1'b1;
        end
`endif
        if (!rstn) begin
            gnt_any = 1'b0;
            gnt_oh  = '0;
        end
    end

    assign gnt = gnt_oh;

    always_comb begin
        ptr_d = ptr_q;
`ifdef SPRITE_ARB_BIRD_PRIO_EN
        if (gnt_any && (gnt_idx != '0)) begin
`else
        if (gnt_any) begin
`endif
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        // Frame start re-seeds the pointer and wins over a same-cycle grant update.
        if (frame_start) begin
`ifdef SPRITE_ARB_BIRD_PRIO_EN
            ptr_d = PW'(1);
`else
            ptr_d = '0;
`endif
        end
    end

    always_comb begin
        rom_en_d   = gnt_any;
        rom_addr_d = rom_addr_q;
        if (gnt_any) begin
            rom_addr_d = addr[32'(gnt_idx)*AW +: AW];
        end
        tag_d      = {tag_q[ROM_LAT-1:0], gnt_oh};
        rd_valid_d = tag_q[ROM_LAT];
        rd_data_d  = (|tag_q[ROM_LAT]) ? rom_data : rd_data_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            tag_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            tag_q      <= tag_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign busy     = rom_en_q | (|tag_q);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model (grant search, pointer, return queue).
module tb_sprite_rom_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 14;
    localparam int DW      = 12;
    localparam int ROM_LAT = 2;
    localparam int RET     = ROM_LAT + 2;

    logic                 clk;
    logic                 rstn;
    logic                 frame_start;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ-1:0]      gnt;
    logic                 rom_en;
    logic [AW-1:0]        rom_addr;
    logic [DW-1:0]        rom_data;
    logic [NREQ-1:0]      rd_valid;
    logic [DW-1:0]        rd_data;
    logic                 busy;

    int errors = 0;
    int checks = 0;

    sprite_rom_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .frame_start (frame_start),
        .req         (req),
        .addr        (addr),
        .gnt         (gnt),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data for an address presented with rom_en appears ROM_LAT cycles later.
    logic [AW-1:0] rom_pipe [ROM_LAT];
    initial for (int i = 0; i < ROM_LAT; i++) rom_pipe[i] = '0;
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1][11:0] ^ 12'hA5A;

    function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
        return a[11:0] ^ 12'hA5A;
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] r, input int p);
`ifdef SPRITE_ARB_BIRD_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
`ifdef SPRITE_ARB_BIRD_PRIO_EN
            if (i == 0) continue;
`endif
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] v);
        addr[i*AW +: AW] = v;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req = '0;
        frame_start = 1'b0;
        addr = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req = 4'b1111;
        frame_start = 1'b0;
        @(negedge clk);
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en: got %b want 0", rom_en); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
        checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0000", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        req = '0;
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        req = 4'b0001;
        set_addr(0, 14'h010);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
            end
            if (k == 1) begin
                checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL single_rom_en: got %b want 1", rom_en); end
                checks++; if (rom_addr !== 14'h010) begin errors++; $display("FAIL single_rom_addr: got %h want 010", rom_addr); end
            end
            if (k >= 1 && k <= 3) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c%0d: got %b want 1", k, busy); end
            end
            if (k < 4) begin
                checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL single_early_rv_c%0d: got %b want 0000", k, rd_valid); end
            end else begin
                checks++; if (rd_valid !== 4'b0001) begin errors++; $display("FAIL single_rd_valid: got %b want 0001", rd_valid); end
                checks++; if (rd_data !== 12'hA4A) begin errors++; $display("FAIL single_rd_data: got %h want a4a", rd_data); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
            end
            @(posedge clk); #1;
            req = '0;
        end
    endtask

`ifndef SPRITE_ARB_BIRD_PRIO_EN
    task automatic test_fairness();
        logic [NREQ-1:0] eg;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(14'h100 + i));
        for (int k = 0; k < 12; k++) begin
            req = (k < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            eg = (k < 8) ? NREQ'(1 << (k % 4)) : '0;
            checks++; if (gnt !== eg) begin errors++; $display("FAIL fair_gnt_c%0d: got %b want %b", k, gnt, eg); end
            if (k >= 4) begin
                eg = NREQ'(1 << ((k - 4) % 4));
                checks++; if (rd_valid !== eg) begin errors++; $display("FAIL fair_rv_c%0d: got %b want %b", k, rd_valid, eg); end
                checks++; if (rd_data !== romf(AW'(14'h100 + (k - 4) % 4))) begin
                    errors++; $display("FAIL fair_rd_data_c%0d: got %h want %h", k, rd_data, romf(AW'(14'h100 + (k - 4) % 4)));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sparse();
        logic [3:0] rq [5] = '{4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b1010};
        logic [3:0] eg [5] = '{4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b1000};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            req = rq[k];
            @(negedge clk);
            checks++; if (gnt !== eg[k]) begin errors++; $display("FAIL sparse_gnt_c%0d: got %b want %b", k, gnt, eg[k]); end
            if (k == 3) begin
                checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL sparse_rom_en_busy: got %b want 1", rom_en); end
            end
            if (k == 4) begin
                checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL sparse_rom_en_idle: got %b want 0", rom_en); end
            end
            @(posedge clk); #1;
        end
        req = '0;
    endtask

    task automatic test_frame_start();
        logic [3:0] rq [7] = '{4'b0010, 4'b1111, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b0};
        logic       fs [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] eg [7] = '{4'b0010, 4'b0100, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0};
        logic [3:0] ev [7] = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0010, 4'b0100, 4'b0001};
        int         own [7] = '{0, 0, 0, 0, 1, 2, 0};
        do_reset();
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(14'h200 + 3 * i));
        for (int k = 0; k < 7; k++) begin
            req = rq[k];
            frame_start = fs[k];
            @(negedge clk);
            checks++; if (gnt !== eg[k]) begin errors++; $display("FAIL fs_gnt_c%0d: got %b want %b", k, gnt, eg[k]); end
            checks++; if (rd_valid !== ev[k]) begin errors++; $display("FAIL fs_rv_c%0d: got %b want %b", k, rd_valid, ev[k]); end
            if (ev[k] != 4'b0) begin
                checks++; if (rd_data !== romf(AW'(14'h200 + 3 * own[k]))) begin
                    errors++; $display("FAIL fs_rd_data_c%0d: got %h want %h", k, rd_data, romf(AW'(14'h200 + 3 * own[k])));
                end
            end
            @(posedge clk); #1;
        end
        frame_start = 1'b0;
    endtask
`else
    task automatic test_bird_prio();
        logic [3:0] rq [4] = '{4'b0010, 4'b1110, 4'b1111, 4'b1110};
        logic [3:0] eg [4] = '{4'b0010, 4'b0100, 4'b0001, 4'b1000};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req = rq[k];
            @(negedge clk);
            checks++; if (gnt !== eg[k]) begin errors++; $display("FAIL prio_gnt_c%0d: got %b want %b", k, gnt, eg[k]); end
            @(posedge clk); #1;
        end
        req = '0;
    endtask
`endif

    task automatic test_reset_midflight();
        do_reset();
        req = 4'b0001;
        set_addr(0, 14'h020);
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt: got %b want 0001", gnt); end
        @(posedge clk); #1 req = '0;
        @(posedge clk); #1 rstn = 1'b0; req = 4'b1111;
        @(negedge clk);
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL mid_rst_gnt: got %b want 0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL mid_rst_rom_en: got %b want 0", rom_en); end
        checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL mid_rst_rv: got %b want 0000", rd_valid); end
        @(posedge clk); #1 rstn = 1'b1; req = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL mid_stale_rv_c%0d: got %b want 0000", k, rd_valid); end
            @(posedge clk); #1;
        end
        req = 4'b1111;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_post_gnt: got %b want 0001", gnt); end
        @(posedge clk); #1 req = '0;
    endtask

    typedef struct {
        int              due;
        logic [NREQ-1:0] oh;
        logic [DW-1:0]   data;
    } exp_t;

    task automatic test_random();
        exp_t            q [$];
        exp_t            e;
        int              mptr;
        int              eg;
        int              dens;
        logic            exp_en;
        logic [AW-1:0]   exp_addr;
        logic [NREQ-1:0] egv;
        int              dens_t [4] = '{20, 60, 100, 40};
        do_reset();
        mptr = 0;
        exp_en = 1'b0;
        exp_addr = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            eg = exp_grant(req, mptr);
            egv = (eg >= 0) ? NREQ'(1 << eg) : '0;
            checks++; if (gnt !== egv) begin errors++; $display("FAIL rand_gnt_c%0d: got %b want %b", c, gnt, egv); end
            checks++; if (rom_en !== exp_en) begin errors++; $display("FAIL rand_rom_en_c%0d: got %b want %b", c, rom_en, exp_en); end
            checks++; if (rom_addr !== exp_addr) begin errors++; $display("FAIL rand_rom_addr_c%0d: got %h want %h", c, rom_addr, exp_addr); end
            if (q.size() > 0 && q[0].due == c) begin
                e = q.pop_front();
                checks++; if (rd_valid !== e.oh) begin errors++; $display("FAIL rand_rv_c%0d: got %b want %b", c, rd_valid, e.oh); end
                checks++; if (rd_data !== e.data) begin errors++; $display("FAIL rand_rd_data_c%0d: got %h want %h", c, rd_data, e.data); end
            end else begin
                checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL rand_rv_idle_c%0d: got %b want 0000", c, rd_valid); end
            end
            checks++; if (busy !== (q.size() != 0)) begin errors++; $display("FAIL rand_busy_c%0d: got %b want %b", c, busy, q.size() != 0); end

            exp_en = (eg >= 0);
            if (eg >= 0) begin
                exp_addr = addr[eg*AW +: AW];
                e.due = c + RET;
                e.oh = egv;
                e.data = romf(exp_addr);
                q.push_back(e);
`ifdef SPRITE_ARB_BIRD_PRIO_EN
                if (eg != 0) mptr = (eg + 1) % NREQ;
`else
                mptr = (eg + 1) % NREQ;
`endif
            end
`ifdef SPRITE_ARB_BIRD_PRIO_EN
            if (frame_start) mptr = 1;
`else
            if (frame_start) mptr = 0;
`endif

            @(posedge clk); #1;
            dens = dens_t[(c / 100) % 4];
            for (int i = 0; i < NREQ; i++) begin
                if (i == eg) begin
                    if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
                    else set_addr(i, AW'($urandom));
                end else if (!req[i] && $urandom_range(99, 0) < dens) begin
                    req[i] = 1'b1;
                    set_addr(i, AW'($urandom));
                end
            end
            frame_start = ($urandom_range(15, 0) == 0);
        end
        req = '0;
        frame_start = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        req = '0;
        addr = '0;
        frame_start = 1'b0;
        test_reset();
        test_single_read();
`ifndef SPRITE_ARB_BIRD_PRIO_EN
        test_fairness();
        test_sparse();
        test_frame_start();
`else
        test_bird_prio();
`endif
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
